cpu_fetch: RTL and testbench
============================

CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- PC_START, 16'h0200, PC value loaded after reset.
- MEM_AW, 12, program-memory byte-address width.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- mem_rd  out  1  byte read strobe to program memory.
- mem_addr  out  MEM_AW  byte address.
- mem_data  in  8  read data, valid the cycle after mem_rd.
- pc_rd  in  16  current PC from the register file.
- pc_en  out  1  PC write enable to the register file.
- pc_wr  out  16  new PC value.
- op_valid  out  1  opcode available to decode.
- op  out  16  opcode, {high byte, low byte}.
- op_addr  out  16  PC the opcode was fetched from.
- op_ready  in  1  decode accepts op.
- redirect  in  1  execute requests a PC change (jump, call, return, skip).
- redirect_addr  in  16  target PC.

Function
REQ-004 The FSM SHALL have exactly these states: INIT, FETCH_HI, FETCH_LO, LATCH, VALID.
REQ-005 INIT SHALL assert pc_en=1 and pc_wr=PC_START, and SHALL then go unconditionally to FETCH_HI; redirect SHALL be ignored in INIT.
REQ-006 FETCH_HI SHALL assert mem_rd=1 with mem_addr=pc_rd[MEM_AW-1:0], then go to FETCH_LO.
REQ-007 FETCH_LO SHALL capture mem_data as the high byte, assert mem_rd=1 with mem_addr=pc_rd[MEM_AW-1:0]+1 (modulo 2^MEM_AW, so 0xFFF wraps to 0x000), then go to LATCH.
REQ-008 LATCH SHALL register op={high, mem_data} and op_addr=pc_rd, then go to VALID.
REQ-009 VALID SHALL hold op_valid=1, with op and op_addr stable, until op_ready=1.
REQ-010 On op_ready=1 in VALID with redirect=0, the block SHALL assert pc_en=1 and pc_wr=pc_rd+2 (16-bit, wrapping 0xFFFF+2 to 0x0001), and go to FETCH_HI next cycle.
REQ-011 Latency SHALL be: FETCH_HI in cycle n gives op_valid=1 in cycle n+3; the minimum issue interval SHALL be 4 cycles per opcode.
REQ-012 Redirect=1 in FETCH_HI, FETCH_LO, LATCH or VALID SHALL abort the fetch, and in that cycle assert pc_en=1, pc_wr=redirect_addr, and op_valid=0 in the following cycle; the next state SHALL be FETCH_HI.
REQ-013 Redirect and op_ready both high in VALID: redirect SHALL win and pc_wr=redirect_addr; decode SHALL treat the opcode as not accepted.
REQ-014 pc_en SHALL be asserted only in the cases given in REQ-005, REQ-010 and REQ-012; pc_wr SHALL be 16'h0 whenever pc_en=0.
REQ-015 mem_rd SHALL be 1 only in FETCH_HI and FETCH_LO; mem_addr SHALL be 0 whenever mem_rd=0.
REQ-016 op_valid SHALL be 1 only in VALID.
REQ-017 Odd PC values SHALL be fetched as-is, with no alignment fault.
REQ-018 The block SHALL issue at most one mem_rd per cycle and SHALL never assert mem_rd and pc_en together, except when redirect aborts FETCH_HI or FETCH_LO; in that case the read data SHALL be discarded.

Reset
REQ-019 While rst=0 the block SHALL asynchronously force the following:
- state=INIT, op_valid=0, op=0, op_addr=0.
- mem_rd=0, mem_addr=0.
- pc_en=1, pc_wr=PC_START.
REQ-020 Reset asserted mid-fetch or mid-VALID SHALL drop op_valid immediately (asynchronously) and discard any partial opcode.
REQ-021 After rst deasserts, INIT SHALL last exactly one cycle.

Verification
REQ-022 Reset release, memory[0x200]=0x12, [0x201]=0x34, op_ready=1 -> pc_en=1/pc_wr=0x0200 once; reads at 0x200 and 0x201; op=0x1234 and op_addr=0x0200 in the 4th cycle after INIT; then pc_wr=0x0202.
REQ-023 op_ready=0 for 10 cycles in VALID -> op_valid, op and op_addr stable throughout, no mem_rd, no pc_en; op_ready=1 -> single pc_en with pc_wr=0x0202.
REQ-024 Redirect=1 with redirect_addr=0x0300 during FETCH_LO -> pc_wr=0x0300 that cycle, no op_valid for the aborted fetch, next read at 0x300.
REQ-025 Redirect=1 (0x0250) and op_ready=1 together in VALID -> pc_wr=0x0250, not 0x0202; next op_addr=0x0250.
REQ-026 PC=0x0FFF -> reads at 0xFFF then 0x000; PC=0xFFFF accepted -> pc_wr=0x0001.
REQ-027 rst pulsed low during VALID -> op_valid=0 immediately; after release, INIT with pc_wr=0x0200, and fetch restarts.

Source files
------------

// File: rtl/cpu_fetch_if.sv
// Fetch-unit bus bundle: program-memory byte port, PC register-file port,
// opcode handshake towards decode and the redirect request from execute.
interface cpu_fetch_if #(
    parameter int MEM_AW = 12
);
    logic              mem_rd;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic [15:0]       pc_rd;
    logic              pc_en;
    logic [15:0]       pc_wr;
    logic              op_valid;
    logic [15:0]       op;
    logic [15:0]       op_addr;
    logic              op_ready;
    logic              redirect;
    logic [15:0]       redirect_addr;

    // Fetch unit side
    modport master (
        output mem_rd, mem_addr, pc_en, pc_wr, op_valid, op, op_addr,
        input  mem_data, pc_rd, op_ready, redirect, redirect_addr
    );

    // Environment side: memory, register file, decode and execute
    modport slave (
        input  mem_rd, mem_addr, pc_en, pc_wr, op_valid, op, op_addr,
        output mem_data, pc_rd, op_ready, redirect, redirect_addr
    );
endinterface

// File: rtl/cpu_fetch.sv
// Two-byte opcode fetch unit. Reads the high byte then the low byte of each
// opcode from a byte-wide program memory, presents the assembled opcode to
// decode with a valid/ready handshake and advances the PC by two on accept.
// A redirect from execute aborts any fetch in flight and loads a new PC.
module cpu_fetch #(
    parameter logic [15:0] PC_START = 16'h0200,
    parameter int          MEM_AW   = 12
) (
    input  logic       clk,
    input  logic       rst,
    cpu_fetch_if.master bus
);

    typedef enum logic [2:0] {
        INIT,
        FETCH_HI,
        FETCH_LO,
        LATCH,
        VALID
    } state_t;

    state_t state, state_nxt;

    logic [7:0]  hi_p1;
    logic [15:0] op_p2;
    logic [15:0] op_addr_p2;

    logic              mem_rd;
    logic [MEM_AW-1:0] mem_addr;
    logic              pc_en;
    logic [15:0]       pc_wr;
    logic              op_valid;
    logic              fetching;

    // Low-byte address: wraps at the top of program memory.
    function automatic logic [MEM_AW-1:0] next_byte_addr(input logic [MEM_AW-1:0] a);
        return a + {{(MEM_AW-1){1'b0}}, 1'b1};
    endfunction

    // Sequential PC step: 16-bit wrap, odd PCs stay odd.
    function automatic logic [15:0] pc_step(input logic [15:0] pc);
        return pc + 16'd2;
    endfunction

    // State register; reset parks the FSM in INIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Opcode assembly: high byte arrives in FETCH_LO, low byte in LATCH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_p1      <= 8'h00;
            op_p2      <= 16'h0000;
            op_addr_p2 <= 16'h0000;
        end else begin
            if (state == FETCH_LO) begin
                hi_p1 <= bus.mem_data;
            end
            if (state == LATCH && !bus.redirect) begin
                op_p2      <= {hi_p1, bus.mem_data};
                op_addr_p2 <= bus.pc_rd;
            end
        end
    end

    assign fetching = (state == FETCH_HI) || (state == FETCH_LO) ||
                      (state == LATCH)    || (state == VALID);

    // Next state and strobes; redirect overrides everything except INIT.
    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        pc_en     = 1'b0;
        pc_wr     = 16'h0000;
        op_valid  = 1'b0;

        case (state)
            INIT: begin
                pc_en     = 1'b1;
                pc_wr     = PC_START;
                state_nxt = FETCH_HI;
            end
            FETCH_HI: begin
                mem_rd    = 1'b1;
                mem_addr  = bus.pc_rd[MEM_AW-1:0];
                state_nxt = FETCH_LO;
            end
            FETCH_LO: begin
                mem_rd    = 1'b1;
                mem_addr  = next_byte_addr(bus.pc_rd[MEM_AW-1:0]);
                state_nxt = LATCH;
            end
            LATCH: begin
                state_nxt = VALID;
            end
            VALID: begin
                op_valid = 1'b1;
                if (bus.op_ready) begin
                    pc_en     = 1'b1;
                    pc_wr     = pc_step(bus.pc_rd);
                    state_nxt = FETCH_HI;
                end
            end
            default: begin
                state_nxt = INIT;
            end
        endcase

        if (fetching && bus.redirect) begin
            pc_en     = 1'b1;
            pc_wr     = bus.redirect_addr;
            state_nxt = FETCH_HI;
        end
    end

    assign bus.mem_rd   = mem_rd;
    assign bus.mem_addr = mem_addr;
    assign bus.pc_en    = pc_en;
    assign bus.pc_wr    = pc_wr;
    assign bus.op_valid = op_valid;
    assign bus.op       = op_p2;
    assign bus.op_addr  = op_addr_p2;

endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: models program memory and the PC register, queues the
// opcodes decode should accept and compares them on each handshake.
module tb_cpu_fetch;

    localparam int MEM_AW = 12;

    logic clk;
    logic rst;

    cpu_fetch_if #(.MEM_AW(MEM_AW)) bus ();

    cpu_fetch #(
        .PC_START (16'h0200),
        .MEM_AW   (MEM_AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] addr;
        logic [15:0] op;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  mem [0:(1<<MEM_AW)-1];
    logic [15:0] pc_reg;
    int          n_checks = 0;
    int          n_err    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
    end

    // PC register file entry.
    always @(posedge clk) begin
        if (bus.pc_en) pc_reg <= bus.pc_wr;
    end
    assign bus.pc_rd = pc_reg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (bus.op_valid) seen = 1'b1;
        end
        chk("valid_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] o);
        exp_t e;
        e.addr = a;
        e.op   = o;
        sb_q.push_back(e);
    endtask

    // Accept monitor and bus invariants, sampled mid-cycle.
    always begin
        exp_t        e;
        logic [15:0] nxt;
        @(negedge clk);
        #3;
        if (rst && bus.op_valid && bus.op_ready && !bus.redirect) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_accept", {16'd0, bus.op_addr}, 32'hFFFF_FFFF);
            end else begin
                e   = sb_q.pop_front();
                nxt = e.addr + 16'd2;
                chk("sb_op", {16'd0, bus.op}, {16'd0, e.op});
                chk("sb_op_addr", {16'd0, bus.op_addr}, {16'd0, e.addr});
                chk("sb_accept_pc_en", {31'd0, bus.pc_en}, 32'd1);
                chk("sb_accept_pc_wr", {16'd0, bus.pc_wr}, {16'd0, nxt});
            end
        end
        chk("inv_addr_idle", {31'd0, (bus.mem_rd || bus.mem_addr == '0)}, 32'd1);
        chk("inv_pcwr_idle", {31'd0, (bus.pc_en || bus.pc_wr == 16'h0)}, 32'd1);
        chk("inv_rd_and_pc", {31'd0, !(bus.mem_rd && bus.pc_en && !bus.redirect)}, 32'd1);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = 8'h00;
        mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
        mem[12'h202] = 8'h56; mem[12'h203] = 8'h78;
        mem[12'h204] = 8'h11; mem[12'h205] = 8'h22;
        mem[12'h300] = 8'h9A; mem[12'h301] = 8'hBC;
        mem[12'h302] = 8'h44; mem[12'h303] = 8'h55;
        mem[12'h250] = 8'hAB; mem[12'h251] = 8'hCD;
        mem[12'hFFF] = 8'hEE; mem[12'h000] = 8'hFF;
        mem[12'h001] = 8'h61; mem[12'h002] = 8'h62;

        rst               = 1'b0;
        bus.op_ready      = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = 16'h0000;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_op_valid", {31'd0, bus.op_valid}, 32'd0);
        chk("rst_op", {16'd0, bus.op}, 32'h0);
        chk("rst_op_addr", {16'd0, bus.op_addr}, 32'h0);
        chk("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
        chk("rst_mem_addr", {20'd0, bus.mem_addr}, 32'h0);
        chk("rst_pc_en", {31'd0, bus.pc_en}, 32'd1);
        chk("rst_pc_wr", {16'd0, bus.pc_wr}, 32'h0200);

        // First opcode after reset, decode always ready
        push(16'h0200, 16'h1234);
        @(negedge clk); rst = 1'b1; bus.op_ready = 1'b1; #1;
        chk("init_pc_en", {31'd0, bus.pc_en}, 32'd1);
        chk("init_pc_wr", {16'd0, bus.pc_wr}, 32'h0200);
        @(negedge clk); #1;
        chk("fhi_mem_rd", {31'd0, bus.mem_rd}, 32'd1);
        chk("fhi_mem_addr", {20'd0, bus.mem_addr}, 32'h200);
        chk("fhi_pc_en", {31'd0, bus.pc_en}, 32'd0);
        @(negedge clk); #1;
        chk("flo_mem_addr", {20'd0, bus.mem_addr}, 32'h201);
        @(negedge clk); #1;
        chk("latch_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
        chk("latch_op_valid", {31'd0, bus.op_valid}, 32'd0);
        @(negedge clk); #1;
        chk("lat_op_valid", {31'd0, bus.op_valid}, 32'd1);
        chk("lat_op", {16'd0, bus.op}, 32'h1234);
        chk("lat_pc_wr", {16'd0, bus.pc_wr}, 32'h0202);

        // Decode stalls for 10 cycles
        @(negedge clk); bus.op_ready = 1'b0;
        push(16'h0202, 16'h5678);
        wait_valid(10);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("stall_op_valid", {31'd0, bus.op_valid}, 32'd1);
            chk("stall_op", {16'd0, bus.op}, 32'h5678);
            chk("stall_op_addr", {16'd0, bus.op_addr}, 32'h0202);
            chk("stall_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
            chk("stall_pc_en", {31'd0, bus.pc_en}, 32'd0);
        end
        @(negedge clk); bus.op_ready = 1'b1; #1;
        chk("stall_rel_pc_en", {31'd0, bus.pc_en}, 32'd1);
        chk("stall_rel_pc_wr", {16'd0, bus.pc_wr}, 32'h0204);

        // Redirect during FETCH_LO
        @(negedge clk); #1;
        chk("r1_fhi_addr", {20'd0, bus.mem_addr}, 32'h204);
        @(negedge clk); bus.redirect = 1'b1; bus.redirect_addr = 16'h0300; #1;
        chk("r1_pc_en", {31'd0, bus.pc_en}, 32'd1);
        chk("r1_pc_wr", {16'd0, bus.pc_wr}, 32'h0300);
        push(16'h0300, 16'h9ABC);
        @(negedge clk); bus.redirect = 1'b0; #1;
        chk("r1_no_valid", {31'd0, bus.op_valid}, 32'd0);
        chk("r1_next_addr", {20'd0, bus.mem_addr}, 32'h300);
        wait_valid(10);

        // Redirect and op_ready together in VALID
        @(negedge clk); bus.op_ready = 1'b0;
        wait_valid(10);
        chk("r2_op_addr", {16'd0, bus.op_addr}, 32'h0302);
        chk("r2_op", {16'd0, bus.op}, 32'h4455);
        @(negedge clk); bus.op_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_addr = 16'h0250; #1;
        chk("r2_pc_en", {31'd0, bus.pc_en}, 32'd1);
        chk("r2_pc_wr", {16'd0, bus.pc_wr}, 32'h0250);
        push(16'h0250, 16'hABCD);
        @(negedge clk); bus.redirect = 1'b0; #1;
        chk("r2_no_valid", {31'd0, bus.op_valid}, 32'd0);
        wait_valid(10);

        // Redirect in FETCH_HI to 0x0FFF: byte address wrap
        @(negedge clk); bus.redirect = 1'b1; bus.redirect_addr = 16'h0FFF; #1;
        chk("w1_mem_rd", {31'd0, bus.mem_rd}, 32'd1);
        chk("w1_pc_wr", {16'd0, bus.pc_wr}, 32'h0FFF);
        push(16'h0FFF, 16'hEEFF);
        @(negedge clk); bus.redirect = 1'b0; #1;
        chk("w1_hi_addr", {20'd0, bus.mem_addr}, 32'hFFF);
        @(negedge clk); #1;
        chk("w1_lo_addr", {20'd0, bus.mem_addr}, 32'h000);
        wait_valid(10);

        // PC 0xFFFF: 16-bit wrap on accept
        @(negedge clk); bus.redirect = 1'b1; bus.redirect_addr = 16'hFFFF; #1;
        push(16'hFFFF, 16'hEEFF);
        @(negedge clk); bus.redirect = 1'b0; #1;
        chk("w2_hi_addr", {20'd0, bus.mem_addr}, 32'hFFF);
        @(negedge clk); #1;
        chk("w2_lo_addr", {20'd0, bus.mem_addr}, 32'h000);
        wait_valid(10);
        chk("w2_pc_wr", {16'd0, bus.pc_wr}, 32'h0001);

        // Reset pulse while holding VALID
        @(negedge clk); bus.op_ready = 1'b0;
        wait_valid(10);
        chk("odd_op_addr", {16'd0, bus.op_addr}, 32'h0001);
        chk("odd_op", {16'd0, bus.op}, 32'h6162);
        #3; rst = 1'b0; #1;
        chk("arst_op_valid", {31'd0, bus.op_valid}, 32'd0);
        chk("arst_op", {16'd0, bus.op}, 32'h0);
        chk("arst_op_addr", {16'd0, bus.op_addr}, 32'h0);
        chk("arst_pc_wr", {16'd0, bus.pc_wr}, 32'h0200);
        chk("arst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
        repeat (2) @(negedge clk);
        push(16'h0200, 16'h1234);
        @(negedge clk); rst = 1'b1; bus.op_ready = 1'b1; #1;
        chk("re_init_pc_wr", {16'd0, bus.pc_wr}, 32'h0200);
        @(negedge clk); #1;
        chk("re_fhi_mem_rd", {31'd0, bus.mem_rd}, 32'd1);
        chk("re_fhi_addr", {20'd0, bus.mem_addr}, 32'h200);
        wait_valid(10);

        @(negedge clk); #1;
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
